tt_memop_tracker: RTL and testbench

Parametrised in-order tracker for up to DEPTH in-flight vector memory operations (loads/stores) in the VPU execute stage. A new memop may begin issuing uops while older memops are still synchronising or committing. The block serialises the OVI memop sync handshake oldest-first and retires ops in order with a completion pulse. It asserts the OVI stall only when no tracking slot is free.

---
 rtl/tt_memop_tracker_if.sv | 39 +++
 rtl/tt_memop_tracker.sv | 103 ++++++++++
 tb/tb_tt_memop_tracker.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/tt_memop_tracker_if.sv
// Memop tracker bus: uop issue, OVI sync handshake and retire signals.
// The master side drives issue/status inputs; the slave side is the tracker.
interface tt_memop_tracker_if #(
  parameter int DEPTH = 4,
  parameter int ID_W  = $clog2(DEPTH)
);
  logic            i_load;
  logic            i_store;
  logic            i_id_ex_rts;
  logic            i_ex_rtr;
  logic            i_last_uop;
  logic            i_lq_empty;
  logic            i_mem_req;
  logic            i_memop_sync_end;
  logic            o_memop_sync_start;
  logic [ID_W-1:0] o_memop_sync_id;
  logic            o_completed_valid;
  logic [ID_W-1:0] o_completed_id;
  logic            o_completed_is_load;
  logic            o_ovi_stall;
  logic            o_is_load;
  logic [ID_W:0]   o_occupancy;

  modport master (
    output i_load, i_store, i_id_ex_rts, i_ex_rtr, i_last_uop,
    output i_lq_empty, i_mem_req, i_memop_sync_end,
    input  o_memop_sync_start, o_memop_sync_id, o_completed_valid,
    input  o_completed_id, o_completed_is_load, o_ovi_stall,
    input  o_is_load, o_occupancy
  );

  modport slave (
    input  i_load, i_store, i_id_ex_rts, i_ex_rtr, i_last_uop,
    input  i_lq_empty, i_mem_req, i_memop_sync_end,
    output o_memop_sync_start, o_memop_sync_id, o_completed_valid,
    output o_completed_id, o_completed_is_load, o_ovi_stall,
    output o_is_load, o_occupancy
  );
endinterface

// File: rtl/tt_memop_tracker.sv
// In-order tracker for in-flight vector memops: allocates slots,
// serialises the OVI sync handshake oldest-first and retires in order.
module tt_memop_tracker #(
  parameter int DEPTH = 4,
  parameter int ID_W  = $clog2(DEPTH)
) (
  input logic              i_clk,
  input logic              i_reset,
  tt_memop_tracker_if.slave bus
);
  typedef enum logic [1:0] {
    PREPARE, BUSY, SYNC, COMMIT
  } st_e;

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] is_ld;
  st_e              st [DEPTH];
  logic [ID_W-1:0]  tail;
  logic [ID_W-1:0]  sync_ptr;
  logic [ID_W-1:0]  head;
  logic [ID_W:0]    occ;

  logic            fire;
  logic            alloc;
  logic            has_open;
  logic [ID_W-1:0] open_id;
  logic            in_sync;
  logic            sync_go;
  logic            sync_done;
  logic            retire;
  logic            full;

  function automatic logic [ID_W-1:0] inc(input logic [ID_W-1:0] p);
    return (p == ID_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    has_open = 1'b0;
    open_id  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && st[i] == PREPARE) begin
        has_open = 1'b1;
        open_id  = ID_W'(i);
      end
    end
  end

  // Syncs complete in order, so only slot[sync_ptr] can be in SYNC.
  assign fire = bus.i_id_ex_rts && bus.i_ex_rtr
             && (bus.i_load || bus.i_store);
  assign full  = (occ == (ID_W+1)'(DEPTH));
  assign alloc = fire && !has_open && !full;
  assign in_sync = valid[sync_ptr] && st[sync_ptr] == SYNC;
  assign sync_go = valid[sync_ptr] && st[sync_ptr] == BUSY
                && (!is_ld[sync_ptr] || !bus.i_mem_req);
  assign sync_done = in_sync && bus.i_memop_sync_end;
  assign retire = valid[head] && st[head] == COMMIT
               && (!is_ld[head] || bus.i_lq_empty);

  assign bus.o_memop_sync_start  = !i_reset && sync_go;
  assign bus.o_memop_sync_id     = i_reset ? '0 : sync_ptr;
  assign bus.o_completed_valid   = !i_reset && retire;
  assign bus.o_completed_id      = i_reset ? '0 : head;
  assign bus.o_completed_is_load = !i_reset && is_ld[head];
  assign bus.o_ovi_stall         = !i_reset && full && !has_open;
  assign bus.o_is_load           = !i_reset && valid[head] && is_ld[head];
  assign bus.o_occupancy         = i_reset ? '0 : occ;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid    <= '0;
      is_ld    <= '0;
      tail     <= '0;
      sync_ptr <= '0;
      head     <= '0;
      occ      <= '0;
      for (int i = 0; i < DEPTH; i++) st[i] <= PREPARE;
    end else begin
      if (alloc) begin
        valid[tail] <= 1'b1;
        is_ld[tail] <= bus.i_load;
        st[tail]    <= bus.i_last_uop ? BUSY : PREPARE;
        tail        <= inc(tail);
      end else if (fire && has_open && bus.i_last_uop) begin
        st[open_id] <= BUSY;
      end
      if (sync_go) st[sync_ptr] <= SYNC;
      if (sync_done) begin
        st[sync_ptr] <= COMMIT;
        sync_ptr     <= inc(sync_ptr);
      end
      if (retire) begin
        valid[head] <= 1'b0;
        head        <= inc(head);
      end
      unique case ({alloc, retire})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

// File: tb/tb_tt_memop_tracker.sv
// Randomised bench for tt_memop_tracker against a queue-based memop model,
// plus directed sequences with literal expectations.
module tb_tt_memop_tracker;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic run = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  tt_memop_tracker_if #(.DEPTH(DEPTH)) bus ();

  tt_memop_tracker #(.DEPTH(DEPTH)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus.slave)
  );

  // stage: 0 prepare, 1 issued/awaiting sync, 2 syncing, 3 committed
  typedef struct {
    int id;
    bit ld;
    int stage;
  } op_t;

  op_t q[$];
  int  m_tail = 0;

  bit e_open, e_ss, e_ret, e_stall, e_isld;
  int e_oi, e_si, e_ci, e_occ;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", n, a, e, $time);
    end
  endtask

  task automatic model_eval();
    e_open = 0; e_oi = -1; e_si = -1; e_ci = -1;
    foreach (q[i]) begin
      if (q[i].stage == 0) begin e_open = 1; e_oi = i; end
      if (q[i].stage == 2) e_si = i;
      if (q[i].stage < 2 && e_ci < 0) e_ci = i;
    end
    e_ss = (e_si < 0) && (e_ci >= 0) && q[e_ci].stage == 1
        && (!q[e_ci].ld || !bus.i_mem_req);
    e_ret = q.size() > 0 && q[0].stage == 3
         && (!q[0].ld || bus.i_lq_empty);
    e_stall = (q.size() == DEPTH) && !e_open;
    e_isld  = q.size() > 0 ? q[0].ld : 1'b0;
    e_occ   = q.size();
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_tail = 0;
    end else begin
      model_eval();
      if (e_si >= 0 && bus.i_memop_sync_end) q[e_si].stage = 3;
      if (e_ss) q[e_ci].stage = 2;
      if (bus.i_id_ex_rts && bus.i_ex_rtr && (bus.i_load || bus.i_store)) begin
        if (e_open) begin
          if (bus.i_last_uop) q[e_oi].stage = 1;
        end else if (q.size() < DEPTH) begin
          q.push_back('{id: m_tail, ld: bus.i_load,
                        stage: bus.i_last_uop ? 1 : 0});
          m_tail = (m_tail + 1) % DEPTH;
        end
      end
      if (e_ret) void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (run) begin
      model_eval();
      if (rst) begin
        e_ss = 0; e_ret = 0; e_stall = 0; e_isld = 0; e_occ = 0;
      end
      chk("sync_start", bus.o_memop_sync_start, e_ss);
      if (e_ss) chk("sync_id", bus.o_memop_sync_id, q[e_ci].id);
      chk("completed_valid", bus.o_completed_valid, e_ret);
      if (e_ret) begin
        chk("completed_id", bus.o_completed_id, q[0].id);
        chk("completed_is_load", bus.o_completed_is_load, q[0].ld);
      end
      chk("ovi_stall", bus.o_ovi_stall, e_stall);
      chk("is_load", bus.o_is_load, e_isld);
      chk("occupancy", bus.o_occupancy, e_occ);
    end
  end

  task automatic idle();
    bus.i_load = 0; bus.i_store = 0;
    bus.i_id_ex_rts = 0; bus.i_ex_rtr = 0;
    bus.i_last_uop = 0; bus.i_lq_empty = 1;
    bus.i_mem_req = 0; bus.i_memop_sync_end = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(bit ld, bit last);
    bus.i_load = ld; bus.i_store = !ld;
    bus.i_id_ex_rts = 1; bus.i_ex_rtr = 1;
    bus.i_last_uop = last;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    run = 1;
    tick();
    rst = 0;

    // single store
    issue(0, 1);
    @(negedge clk);
    chk("lit_s1_occ_T", bus.o_occupancy, 0);
    chk("lit_s1_ss_T", bus.o_memop_sync_start, 0);
    tick(); idle();
    @(negedge clk);
    chk("lit_s1_ss_T1", bus.o_memop_sync_start, 1);
    chk("lit_s1_sid_T1", bus.o_memop_sync_id, 0);
    chk("lit_s1_occ_T1", bus.o_occupancy, 1);
    tick();
    @(negedge clk);
    chk("lit_s1_ss_T2", bus.o_memop_sync_start, 0);
    tick();
    bus.i_memop_sync_end = 1;
    @(negedge clk);
    chk("lit_s1_cv_T3", bus.o_completed_valid, 0);
    tick(); idle();
    @(negedge clk);
    chk("lit_s1_cv_T4", bus.o_completed_valid, 1);
    chk("lit_s1_cid_T4", bus.o_completed_id, 0);
    chk("lit_s1_cld_T4", bus.o_completed_is_load, 0);
    tick();
    @(negedge clk);
    chk("lit_s1_occ_T5", bus.o_occupancy, 0);

    // 3-uop load held off by mem_req
    issue(1, 0); tick();
    issue(1, 0); tick();
    issue(1, 1); bus.i_mem_req = 1; tick();
    idle(); bus.i_mem_req = 1;
    @(negedge clk);
    chk("lit_ld_ss_memreq", bus.o_memop_sync_start, 0);
    chk("lit_ld_is_load", bus.o_is_load, 1);
    tick();
    @(negedge clk);
    chk("lit_ld_ss_memreq2", bus.o_memop_sync_start, 0);
    tick(); bus.i_mem_req = 0;
    @(negedge clk);
    chk("lit_ld_ss", bus.o_memop_sync_start, 1);
    chk("lit_ld_sid", bus.o_memop_sync_id, 1);
    tick(); bus.i_memop_sync_end = 1; bus.i_lq_empty = 0;
    tick(); bus.i_memop_sync_end = 0;
    @(negedge clk);
    chk("lit_ld_cv_lq_busy", bus.o_completed_valid, 0);
    tick(); bus.i_lq_empty = 1;
    @(negedge clk);
    chk("lit_ld_cv", bus.o_completed_valid, 1);
    chk("lit_ld_cid", bus.o_completed_id, 1);
    tick();

    // fill, stall, ignored fifth fire, id wrap
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 4; i++) begin
      issue(0, 1); tick();
    end
    @(negedge clk);
    chk("lit_full_stall", bus.o_ovi_stall, 1);
    chk("lit_full_occ", bus.o_occupancy, 4);
    tick(); idle();
    @(negedge clk);
    chk("lit_full_occ_after5", bus.o_occupancy, 4);
    bus.i_memop_sync_end = 1;
    repeat (14) tick();
    idle();
    @(negedge clk);
    chk("lit_drain_occ", bus.o_occupancy, 0);
    issue(0, 1); tick(); idle();
    @(negedge clk);
    chk("lit_wrap_sid", bus.o_memop_sync_id, 0);
    chk("lit_wrap_ss", bus.o_memop_sync_start, 1);
    tick();

    // randomised phases
    for (int ph = 0; ph < 4; ph++) begin
      int p_end;
      p_end = (ph % 2 == 0) ? 8 : 60;
      for (int c = 0; c < 1000; c++) begin
        bit l;
        rst = ($urandom_range(0, 399) == 0);
        l = $urandom_range(0, 1);
        bus.i_load = l;
        bus.i_store = !l && ($urandom_range(0, 9) != 0);
        bus.i_id_ex_rts = ($urandom_range(0, 3) != 0);
        bus.i_ex_rtr = ($urandom_range(0, 3) != 0);
        bus.i_last_uop = ($urandom_range(0, 2) == 0);
        bus.i_mem_req = $urandom_range(0, 1);
        bus.i_lq_empty = ($urandom_range(0, 2) != 0);
        bus.i_memop_sync_end = ($urandom_range(0, 99) < p_end);
        tick();
      end
    end

    // reset mid-operation
    rst = 1;
    @(negedge clk);
    chk("lit_rst_occ", bus.o_occupancy, 0);
    chk("lit_rst_stall", bus.o_ovi_stall, 0);
    tick(); rst = 0; idle();
    @(negedge clk);
    chk("lit_postrst_occ", bus.o_occupancy, 0);
    chk("lit_postrst_ss", bus.o_memop_sync_start, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
